// File: rtl/bus_master.sv
// Single-outstanding bus initiator: turns a client req/ack handshake into an
// active-low cs_/as_/rw/rdy_ peripheral bus cycle with a timeout abort.
module bus_master #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cs_,
  output logic              as_,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_
);

  typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                cs_d, as_d, rw_d, ack_d, err_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wr_data_d, rdata_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cs_d       = cs_;
    as_d       = as_;
    rw_d       = rw;
    addr_d     = addr;
    wr_data_d  = wr_data;
    ack_d      = 1'b0;
    err_d      = err_o;
    rdata_d    = rdata_o;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d    = StAccess;
          wait_cnt_d = '0;
          cs_d       = 1'b0;
          as_d       = 1'b0;
          rw_d       = rw_i;
          addr_d     = addr_i;
          wr_data_d  = rw_i ? '0 : wdata_i;
        end
      end
      StAccess: begin
        // A late rdy_ on the last allowed cycle still counts as success.
        if (!rdy_ || wait_cnt_q == TimeoutLast) begin
          state_d   = StRecover;
          ack_d     = 1'b1;
          err_d     = rdy_;
          rdata_d   = (!rdy_ && rw) ? rd_data : '0;
          cs_d      = 1'b1;
          as_d      = 1'b1;
          rw_d      = 1'b1;
          addr_d    = '0;
          wr_data_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StRecover: begin
        // Responders release rdy_ a cycle late, so rdy_ is ignored here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      cs_        <= 1'b1;
      as_        <= 1'b1;
      rw         <= 1'b1;
      addr       <= '0;
      wr_data    <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      rdata_o    <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cs_        <= cs_d;
      as_        <= as_d;
      rw         <= rw_d;
      addr       <= addr_d;
      wr_data    <= wr_data_d;
      ack_o      <= ack_d;
      err_o      <= err_d;
      rdata_o    <= rdata_d;
      busy_o     <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: a registered responder model, a driver that
// queues expected completions, and a monitor that checks every ack_o.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_i = 1'b0;
  logic        rw_i = 1'b0;
  logic [29:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, ack_o, err_o;
  logic [31:0] rdata_o;
  logic        cs_, as_, rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data = '0;
  logic        rdy_;

  bus_master #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .rw_i    (rw_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .rdata_o (rdata_o),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered responder: rdy_ falls in access cycle resp_lat+1.
  int   resp_lat = 1;
  int   ccnt = 0;
  logic rdy_reg = 1'b1;
  logic rdy_force = 1'b0;
  always @(posedge clk) begin
    ccnt    <= cs_ ? 0 : ccnt + 1;
    rdy_reg <= !(!cs_ && (ccnt + 1 >= resp_lat));
  end
  assign rdy_ = rdy_reg && !rdy_force;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;
  exp_t exp_q[$];
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_ack", 64'(ack_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_err", 64'(err_o), 64'(e.err));
          check("ack_rdata", 64'(rdata_o), 64'(e.rdata));
          check("ack_cycle", 64'(cyc), 64'(e.at));
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
        void'(exp_q.pop_front());
        check("ack_missing", 64'(ack_o), 64'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the following posedge samples the request.
  task automatic issue(input logic r, input logic [29:0] a, input logic [31:0] wd);
    req_i   = 1'b1;
    rw_i    = r;
    addr_i  = a;
    wdata_i = wd;
    @(negedge clk);
    req_i   = 1'b0;
    rw_i    = 1'($urandom);
    addr_i  = 30'($urandom);
    wdata_i = $urandom;
  endtask

  task automatic expect_ack(input logic e, input logic [31:0] d, input int dly);
    exp_t x;
    x.err   = e;
    x.rdata = d;
    x.at    = cyc + dly;
    exp_q.push_back(x);
  endtask

  initial begin
    tick(2);
    check("rst_cs", 64'(cs_), 64'd1);
    check("rst_as", 64'(as_), 64'd1);
    check("rst_rw", 64'(rw), 64'd1);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Read, 1-cycle responder.
    rd_data = 32'h0000_00A5;
    expect_ack(1'b0, 32'h0000_00A5, 3);
    issue(1'b1, 30'h2, 32'h1234_5678);
    check("rd_c1_cs", 64'(cs_), 64'd0);
    check("rd_c1_as", 64'(as_), 64'd0);
    check("rd_c1_rw", 64'(rw), 64'd1);
    check("rd_c1_addr", 64'(addr), 64'h2);
    check("rd_c1_wr_data", 64'(wr_data), 64'd0);
    check("rd_c1_busy", 64'(busy_o), 64'd1);
    tick(1);
    check("rd_c2_cs", 64'(cs_), 64'd0);
    tick(1);
    check("rd_c3_cs", 64'(cs_), 64'd1);
    check("rd_c3_addr", 64'(addr), 64'd0);
    tick(1);
    check("rd_c4_busy", 64'(busy_o), 64'd0);
    check("rd_c4_rdata_hold", 64'(rdata_o), 64'hA5);
    tick(1);

    // Write.
    expect_ack(1'b0, 32'h0, 3);
    issue(1'b0, 30'h1, 32'h0000_0003);
    check("wr_c1_rw", 64'(rw), 64'd0);
    check("wr_c1_wr_data", 64'(wr_data), 64'h3);
    check("wr_c1_addr", 64'(addr), 64'h1);
    tick(2);
    check("wr_c3_wr_data", 64'(wr_data), 64'd0);
    check("wr_c3_rw", 64'(rw), 64'd1);
    tick(2);

    // Timeout: responder never answers.
    resp_lat = 1000;
    expect_ack(1'b1, 32'h0, 17);
    issue(1'b1, 30'h5, 32'h0);
    tick(15);
    check("to_c16_cs", 64'(cs_), 64'd0);
    tick(1);
    check("to_c17_cs", 64'(cs_), 64'd1);
    check("to_c17_as", 64'(as_), 64'd1);
    tick(2);

    // rdy_ arrives on the 16th access cycle: success wins over timeout.
    resp_lat = 15;
    rd_data  = 32'hDEAD_BEEF;
    expect_ack(1'b0, 32'hDEAD_BEEF, 17);
    issue(1'b1, 30'h7, 32'h0);
    tick(18);

    // Stale rdy_ low while idle must not produce an ack.
    rdy_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("stale_rdy_ack", 64'(ack_o), 64'd0);
    end
    rdy_force = 1'b0;
    tick(2);

    // Back-to-back: req_i held 12 cycles, alternating read/write.
    resp_lat = 1;
    rd_data  = 32'h0000_5A5A;
    expect_ack(1'b0, 32'h0000_5A5A, 3);
    expect_ack(1'b0, 32'h0, 7);
    expect_ack(1'b0, 32'h0000_5A5A, 11);
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        check("b2b_c5_addr", 64'(addr), 64'd9);
        check("b2b_c5_rw", 64'(rw), 64'd0);
        check("b2b_c5_wr_data", 64'(wr_data), 64'h104);
      end
      req_i   = 1'b1;
      rw_i    = ((k / 4) % 2 == 0);
      addr_i  = 30'(k / 4 + 8);
      wdata_i = 32'(32'h100 + k);
      tick(1);
    end
    req_i = 1'b0;
    tick(3);

    // Reset in cycle 2 of a read: no ack, bus released, results cleared.
    issue(1'b1, 30'h3, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_cs", 64'(cs_), 64'd1);
    check("mid_rst_as", 64'(as_), 64'd1);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_ack", 64'(ack_o), 64'd0);
    check("mid_rst_rdata", 64'(rdata_o), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("post_rst_ack", 64'(ack_o), 64'd0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Single-outstanding bus initiator.
- Converts a simple client request/acknowledge interface into the chip's active-low cs_/as_/rw/rdy_ peripheral bus protocol.
- Drives bus cycles to peripheral responders such as the GPIO and timer blocks, waits for rdy_, and returns read data.
- A bus that never responds is aborted with an error flag after a programmable timeout.

Parameters:
- ADDR_W, 30, width of bus/client address (word address).
- DATA_W, 32, width of read/write data.
- TIMEOUT, 16, maximum ACCESS-state cycles waiting for rdy_ (legal range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_i  in  1  client request strobe; sampled only in IDLE
- rw_i  in  1  client direction: 1 = read, 0 = write
- addr_i  in  ADDR_W  client address
- wdata_i  in  DATA_W  client write data
- busy_o  out  1  high whenever state != IDLE
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with ack_o; 1 = timeout abort
- rdata_o  out  DATA_W  read data; valid with ack_o
- cs_  out  1  bus chip select, active-low
- as_  out  1  bus address strobe, active-low
- rw  out  1  bus direction: 1 = read, 0 = write
- addr  out  ADDR_W  bus address
- wr_data  out  DATA_W  bus write data
- rd_data  in  DATA_W  bus read data from responder
- rdy_  in  1  responder ready, active-low

Behaviour:
- All outputs are registered. Reset is synchronous: on the first clk edge with reset = 1, all state clears.
- Reset values:
  - cs_ = 1, as_ = 1, rw = 1.
  - addr = 0, wr_data = 0.
  - ack_o = 0, err_o = 0, rdata_o = 0, busy_o = 0.
  - state = IDLE, wait_cnt = 0.
- State machine:
  - IDLE: bus outputs at reset values; rdy_ ignored. If req_i = 1, latch addr_i/rw_i/wdata_i into addr/rw/wr_data, drive cs_ = as_ = 0, clear wait_cnt, go ACCESS. wr_data is driven 0 for reads.
  - ACCESS: hold all bus outputs.
    - If rdy_ = 0: go RECOVER; ack_o = 1, err_o = 0; rdata_o = rd_data for reads, 0 for writes.
    - Else if wait_cnt = TIMEOUT-1: go RECOVER; ack_o = 1, err_o = 1, rdata_o = 0.
    - Else wait_cnt increments.
    - rdy_ = 0 on the final timeout cycle takes precedence: success, not error.
  - RECOVER: cs_ = as_ = 1, rw = 1, addr = 0, wr_data = 0. ack_o returns to 0 after one cycle. rdy_ is ignored, because responders deassert rdy_ one cycle late. Unconditionally go IDLE.
- Latency with a registered responder (rdy_ one cycle after cs_/as_):
  - req_i sampled at edge 0; cs_/as_ low in cycle 1; rdy_ low in cycle 2; ack_o high in cycle 3; IDLE in cycle 4.
  - Back-to-back throughput: one transaction per 4 cycles.
- Timeout latency: ack_o with err_o = 1 in cycle TIMEOUT+1 after req_i is sampled.
- req_i while busy_o = 1 is ignored and not queued. The client holds req_i or re-issues it after ack_o.
- Client inputs are not required stable after the sampling edge.
- rdata_o and err_o hold their value until the next ack_o, except that reset clears them.
- Reset mid-transaction: the next edge forces reset values, with cs_/as_ high and no ack_o pulse.
- wait_cnt width is 8 bits and never wraps, because it stops at TIMEOUT-1.

Test Plan:
- Read: req_i = 1, rw_i = 1, addr_i = 0x2, responder returns 0x0000_00A5 with 1-cycle rdy_ -> cs_/as_ low cycles 1–2, ack_o = 1 cycle 3, rdata_o = 0x0000_00A5, err_o = 0.
- Write: rw_i = 0, addr_i = 0x1, wdata_i = 0x0000_0003 -> bus shows rw = 0, wr_data = 0x3 during ACCESS; ack_o cycle 3; rdata_o = 0; wr_data = 0 in RECOVER.
- Timeout: rdy_ held 1, TIMEOUT = 16 -> ACCESS lasts 16 cycles, ack_o = 1 and err_o = 1 in cycle 17, cs_/as_ high in cycle 17.
- Boundary: rdy_ goes 0 exactly on the 16th ACCESS cycle -> err_o = 0 and data captured. Also, stale rdy_ = 0 during RECOVER/IDLE -> no spurious ack_o.
- Back-to-back: req_i held high for 12 cycles with alternating read/write -> 3 transactions with ack_o in cycles 3, 7, 11; req_i during busy is not double-counted.
- Reset in cycle 2 of a read -> cs_/as_ = 1 at the next edge, ack_o never asserted, busy_o = 0.
